// File: rtl/regfile_2r1w_pkg.sv
// Shared sizing constants for the 2-read / 1-write register file.
package regfile_2r1w_pkg;

    localparam int unsigned REG_COUNT  = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [4:0]  REG_ZERO   = 5'd0;
    localparam int unsigned DATA_W     = 32;

endpackage : regfile_2r1w_pkg

// File: rtl/mux32_1.sv
// 32:1 data selector over a flattened bank of 32 WIDTH-bit words.
module mux32_1 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [32*WIDTH-1:0] i_data,
    input  logic [4:0]          i_sel,
    output logic [WIDTH-1:0]    o_data
);

    // Pick the word addressed by i_sel.
    always_comb begin
        o_data = i_data[i_sel*WIDTH +: WIDTH];
    end

endmodule : mux32_1

// File: rtl/regfile_2r1w_reg32.sv
// Single register-file entry: WIDTH-bit D register with load enable and
// asynchronous active-high clear.
module regfile_2r1w_reg32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Hold the stored value; clear immediately on i_clr, load on enable.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule : regfile_2r1w_reg32

// File: rtl/regfile_2r1w.sv
// 32 x WIDTH register file: one synchronous write port, two combinational
// read ports, register 0 hardwired to zero, optional same-cycle bypass.
module regfile_2r1w
    import regfile_2r1w_pkg::*;
#(
    parameter int unsigned WIDTH  = DATA_W,
    parameter int unsigned BYPASS = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ctrl_writeEnable,
    input  logic [REG_ADDR_W-1:0] ctrl_writeReg,
    input  logic [WIDTH-1:0]      data_writeReg,
    input  logic [REG_ADDR_W-1:0] ctrl_readRegA,
    input  logic [REG_ADDR_W-1:0] ctrl_readRegB,
    output logic [WIDTH-1:0]      data_readRegA,
    output logic [WIDTH-1:0]      data_readRegB
);

    localparam logic P_BYPASS = (BYPASS != 0) ? 1'b1 : 1'b0;

    logic [REG_COUNT-1:0]       w_we_dec;
    logic [REG_COUNT*WIDTH-1:0] w_bank;
    logic [WIDTH-1:0]           w_mux_a;
    logic [WIDTH-1:0]           w_mux_b;
    logic                       w_wr_valid;
    logic                       w_byp_a;
    logic                       w_byp_b;

    // One-hot write-enable decode; entry 0 never receives an enable.
    always_comb begin
        w_we_dec = {REG_COUNT{1'b0}};
        if (ctrl_writeEnable && !reset) begin
            w_we_dec[ctrl_writeReg] = 1'b1;
        end else begin
            w_we_dec = {REG_COUNT{1'b0}};
        end
        w_we_dec[0] = 1'b0;
    end

    // Slot 0 of the bank is driven from the always-zero enable bit, so it
    // is structurally a constant zero word.
    assign w_bank[WIDTH-1:0] = {WIDTH{w_we_dec[0]}};

    genvar gi;
    generate
        for (gi = 1; gi < REG_COUNT; gi++) begin : g_reg
            regfile_2r1w_reg32 #(.WIDTH(WIDTH)) u_reg (
                .i_clk (clock),
                .i_clr (reset),
                .i_en  (w_we_dec[gi]),
                .i_d   (data_writeReg),
                .o_q   (w_bank[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate

    mux32_1 #(.WIDTH(WIDTH)) u_mux_a (
        .i_data (w_bank),
        .i_sel  (ctrl_readRegA),
        .o_data (w_mux_a)
    );

    mux32_1 #(.WIDTH(WIDTH)) u_mux_b (
        .i_data (w_bank),
        .i_sel  (ctrl_readRegB),
        .o_data (w_mux_b)
    );

    // Forwarding qualifiers: a live, non-zero write that matches a read index.
    always_comb begin
        w_wr_valid = P_BYPASS && ctrl_writeEnable && !reset &&
                     (ctrl_writeReg != REG_ZERO);
        w_byp_a    = w_wr_valid && (ctrl_writeReg == ctrl_readRegA);
        w_byp_b    = w_wr_valid && (ctrl_writeReg == ctrl_readRegB);
    end

    // Read port A: zero under reset, else forwarded write data or stored word.
    always_comb begin
        if (reset) begin
            data_readRegA = '0;
        end else if (w_byp_a) begin
            data_readRegA = data_writeReg;
        end else begin
            data_readRegA = w_mux_a;
        end
    end

    // Read port B: same selection as port A, independently qualified.
    always_comb begin
        if (reset) begin
            data_readRegB = '0;
        end else if (w_byp_b) begin
            data_readRegB = data_writeReg;
        end else begin
            data_readRegB = w_mux_b;
        end
    end

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w; a bypassing and a
// non-bypassing instance share all inputs.
module tb_regfile_2r1w;

    logic        clock;
    logic        reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic [31:0] nb_readRegA;
    logic [31:0] nb_readRegB;

    int total;
    int bad;

    regfile_2r1w #(.WIDTH(32), .BYPASS(1)) dut (
        .clock            (clock),
        .reset            (reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB)
    );

    regfile_2r1w #(.WIDTH(32), .BYPASS(0)) dut_nb (
        .clock            (clock),
        .reset            (reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (nb_readRegA),
        .data_readRegB    (nb_readRegB)
    );

    // 100 MHz clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write one register at the next rising edge, then drop the strobe.
    task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = idx;
        data_writeReg    = val;
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;
    endtask

    // Directed stimulus sequence.
    initial begin
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        total = 0;
        bad   = 0;
        reset            = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        ctrl_readRegA    = 5'd5;
        ctrl_readRegB    = 5'd31;
        repeat (2) @(posedge clock);
        #1;
        check("reset_a", data_readRegA, 32'h0000_0000);
        check("reset_b", data_readRegB, 32'h0000_0000);
        // Bypass is gated by reset even with a matching write present.
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd5;
        data_writeReg    = 32'h1234_5678;
        #1;
        check("reset_bypass_gated", data_readRegA, 32'h0000_0000);
        ctrl_writeEnable = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // Asynchronous clear without a clock edge.
        write_reg(5'd5, 32'hDEAD_BEEF);
        #1;
        check("r5_written", data_readRegA, 32'hDEAD_BEEF);
        reset = 1'b1;
        #1;
        check("async_clear", data_readRegA, 32'h0000_0000);
        #1;
        reset = 1'b0;
        #1;
        check("clear_after_release", data_readRegA, 32'h0000_0000);
        repeat (2) @(posedge clock);
        #1;
        check("clear_held", data_readRegA, 32'h0000_0000);

        // Fill r1..r31, then sweep both ports in opposite directions.
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'h1000_0000 + 32'(i));
        end
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(31 - i);
            #1;
            exp_a = (i == 0) ? 32'h0000_0000 : 32'h1000_0000 + 32'(i);
            exp_b = (i == 31) ? 32'h0000_0000 : 32'h1000_0000 + 32'(31 - i);
            check("sweep_a", data_readRegA, exp_a);
            check("sweep_b", data_readRegB, exp_b);
            check("sweep_nb_a", nb_readRegA, exp_a);
        end

        // Writes to register 0 are discarded and never forwarded.
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'hFFFF_FFFF;
        ctrl_readRegA    = 5'd0;
        #1;
        check("r0_same_cycle", data_readRegA, 32'h0000_0000);
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;
        check("r0_after_edge", data_readRegA, 32'h0000_0000);

        // Bypass on A while B reads an unrelated register.
        write_reg(5'd7, 32'h0000_0011);
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd7;
        data_writeReg    = 32'h0000_0022;
        ctrl_readRegA    = 5'd7;
        ctrl_readRegB    = 5'd8;
        #1;
        check("byp_a", data_readRegA, 32'h0000_0022);
        check("byp_b_other", data_readRegB, 32'h1000_0008);
        check("nb_a_before", nb_readRegA, 32'h0000_0011);
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;
        check("nb_a_after", nb_readRegA, 32'h0000_0022);
        check("byp_a_after", data_readRegA, 32'h0000_0022);

        // Both ports forwarded from the same write.
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd7;
        data_writeReg    = 32'h0000_0033;
        ctrl_readRegB    = 5'd7;
        #1;
        check("byp_both_a", data_readRegA, 32'h0000_0033);
        check("byp_both_b", data_readRegB, 32'h0000_0033);
        check("nb_both_b", nb_readRegB, 32'h0000_0022);

        // Back-to-back writes to r10: each value visible in its own cycle.
        @(negedge clock);
        ctrl_writeReg = 5'd10;
        data_writeReg = 32'h0000_00A1;
        ctrl_readRegA = 5'd10;
        #1;
        check("b2b_first", data_readRegA, 32'h0000_00A1);
        @(negedge clock);
        data_writeReg = 32'h0000_00A2;
        #1;
        check("b2b_second", data_readRegA, 32'h0000_00A2);
        check("b2b_nb_mid", nb_readRegA, 32'h0000_00A1);
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;
        check("b2b_final", data_readRegA, 32'h0000_00A2);
        check("b2b_nb_final", nb_readRegA, 32'h0000_00A2);

        // Write strobe low: no store, no forwarding.
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd9;
        data_writeReg    = 32'h0000_00AB;
        ctrl_readRegA    = 5'd9;
        #1;
        check("we_low_no_byp", data_readRegA, 32'h1000_0009);
        repeat (3) @(posedge clock);
        #1;
        check("we_low_held", data_readRegA, 32'h1000_0009);

        // Reset across a write edge wins; next edge's write lands.
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd3;
        data_writeReg    = 32'h0000_0055;
        ctrl_readRegA    = 5'd3;
        reset            = 1'b1;
        @(posedge clock);
        #1;
        check("collide_in_reset", data_readRegA, 32'h0000_0000);
        @(negedge clock);
        reset         = 1'b0;
        data_writeReg = 32'h0000_0066;
        #1;
        check("collide_lost_nb", nb_readRegA, 32'h0000_0000);
        check("collide_byp", data_readRegA, 32'h0000_0066);
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;
        check("collide_landed", data_readRegA, 32'h0000_0066);
        check("collide_landed_nb", nb_readRegA, 32'h0000_0066);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_2r1w

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- 32-entry x 32-bit register file: one synchronous write port, two combinational read ports.
- Sits directly upstream of the 32:1 read-select muxes. It holds the 32 register values; one mux32_1 instance per read port selects from them.
- Serves the Pacman processor datapath: decode reads rs/rt, writeback writes rd.
- Register 0 is hardwired to zero. An optional same-cycle write-to-read bypass removes the writeback-to-decode hazard.

Parameters:
- WIDTH, 32, data width of each register. Must equal the mux32_1 data width.
- BYPASS, 1, 1 = same-cycle write data is forwarded to a matching read port; 0 = reads return only stored contents.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- ctrl_writeEnable  input  1  write strobe, sampled at the rising clock edge.
- ctrl_writeReg  input  5  destination register index.
- data_writeReg  input  WIDTH  write data.
- ctrl_readRegA  input  5  read port A index.
- ctrl_readRegB  input  5  read port B index.
- data_readRegA  output  WIDTH  read port A data.
- data_readRegB  output  WIDTH  read port B data.

Behaviour:
- Reset:
  - reset=1 clears registers 1..31 to 0 immediately, without waiting for a clock edge.
  - While reset is held, both read outputs are 0, including the bypass path (bypass is gated by !reset).
- Write:
  - At a rising edge with ctrl_writeEnable=1, reset=0 and ctrl_writeReg!=0, the addressed register loads data_writeReg. All other registers hold.
  - Write enable is decoded 5-to-32 as one-hot. Bit 0 of the decoded enable is forced to 0.
- Register 0: never stored. Always reads 0. A write to index 0 is silently discarded and is never bypassed.
- Read:
  - Purely combinational, zero-cycle latency from the index change.
  - Each port is a mux32_1 over {0, r1..r31}.
  - Without bypass, a write becomes visible on the outputs after the write edge (next cycle).
- Bypass (BYPASS=1):
  - If ctrl_writeEnable=1, ctrl_writeReg!=0, ctrl_writeReg==ctrl_readRegX and reset=0, then data_readRegX = data_writeReg in the same cycle.
  - Each port is bypassed independently. A==B==writeReg forwards to both.
- Reset during a write:
  - Reset asserted at or across a clock edge wins; the write is lost.
  - The first write honoured is at the first rising edge after reset deasserts.
- Multiple writes: one write per cycle. Back-to-back writes to the same index leave the last value; each intermediate value is readable in its own cycle via bypass.
- Out-of-range indices are impossible (5-bit index, 32 entries). Every X-free input combination yields an X-free output.

Decomposition:
- Shared package/include holds:
  - REG_COUNT = 32
  - REG_ADDR_W = 5
  - REG_ZERO = 5'd0
  - DATA_W = 32
- Sub-module reg32: WIDTH-bit D register with enable and asynchronous active-high clear. Instantiated 31 times (r1..r31).
- Read selection reuses the existing mux32_1, one instance per port, with reg0 tied to 0.
- The 5-to-32 write decoder and the bypass compare stay inline.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, assert reset mid-cycle (no clock edge) -> data_readRegA with readRegA=5 drops to 0 immediately; stays 0 after release until rewritten.
- Write/readback: write r1..r31 with value 0x1000_0000+index over 31 cycles, then sweep readRegA 0..31 and readRegB 31..0 -> each returns 0x1000_0000+index; index 0 returns 0.
- Register 0: writeEnable=1, writeReg=0, data=0xFFFFFFFF; readRegA=0 in the same cycle and after the edge -> 0 both times.
- Bypass: BYPASS=1, r7 holds 0x11; writeReg=7, data=0x22, readRegA=7, readRegB=8 in the same cycle -> A=0x22 before the edge, B = r8 contents. With BYPASS=0 -> A=0x11 before the edge, 0x22 after.
- Write-enable low: writeEnable=0, writeReg=9, data=0xAB for several edges -> r9 unchanged, no bypass.
- Reset vs write collision: reset asserted across an edge where writeEnable=1, writeReg=3, data=0x55 -> r3=0 after reset release; the write at the next edge (data=0x66) lands, and r3 reads 0x66.
